// File: rtl/uart_pkg.sv
// Shared UART definitions: sampling constants and the majority-vote helper
// used by the receive-path bit sampler.
package uart_pkg;

  localparam int   MIN_PRESCALE = 8;
  localparam logic SAMP_MODE_3  = 1'b0;
  localparam logic SAMP_MODE_5  = 1'b1;
  localparam logic RX_IDLE      = 1'b1;

  typedef struct packed {
    logic value;
    logic noise;
  } vote_t;

  // samples[0] is the newest sample; 3-sample mode looks at samples[2:0] only.
  function automatic vote_t majority_vote(input logic [4:0] samples, input logic mode);
    vote_t      r;
    logic [2:0] ones;
    ones = '0;
    if (mode == SAMP_MODE_5) begin
      for (int i = 0; i < 5; i++) ones = ones + {2'b00, samples[i]};
      r.value = (ones >= 3'd3);
      r.noise = (ones != 3'd0) && (ones != 3'd5);
    end else begin
      for (int i = 0; i < 3; i++) ones = ones + {2'b00, samples[i]};
      r.value = (ones >= 3'd2);
      r.noise = (ones != 3'd0) && (ones != 3'd3);
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Handshake between the RX control FSM (master) and the bit sampler (slave).
//   samp_en, prescale, samp_mode         : FSM -> sampler
//   sampled_bit, bit_valid, noise_err,
//   edge_cnt                             : sampler -> FSM
interface uart_rx_sampler_if #(
  parameter int PRESCALE_W = 6
);
  logic                  samp_en;
  logic [PRESCALE_W-1:0] prescale;
  logic                  samp_mode;
  logic                  sampled_bit;
  logic                  bit_valid;
  logic                  noise_err;
  logic [PRESCALE_W-1:0] edge_cnt;

  modport master (
    output samp_en, prescale, samp_mode,
    input  sampled_bit, bit_valid, noise_err, edge_cnt
  );

  modport slave (
    input  samp_en, prescale, samp_mode,
    output sampled_bit, bit_valid, noise_err, edge_cnt
  );
endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous input.
//   clk, rst (async, active-low) : clock / reset
//   d                            : asynchronous input
//   q                            : synchronised output, RESET_VAL during reset
module bit_synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= {STAGES{RESET_VAL}};
    else      sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling bit sampler for the UART receive path. Synchronises rx_in,
// counts clk edges across each bit period while samp_en is high, takes 3 or
// 5 samples centred on the bit and majority-votes them into a registered bit.
//   clk, rst (async, active-low) : clock / reset
//   rx_in                        : raw serial line
//   smp (slave)                  : samp_en/prescale/samp_mode in,
//                                  sampled_bit/bit_valid/noise_err/edge_cnt out
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  uart_rx_sampler_if.slave   smp
);

  localparam logic [PRESCALE_W-1:0] PS_MIN = PRESCALE_W'(MIN_PRESCALE);

  logic                  rx_s;
  logic                  samp_en_q;
  logic [PRESCALE_W-1:0] ps_q;
  logic                  mode_q;
  logic [PRESCALE_W-1:0] edge_cnt_q;
  logic [4:0]            samp_sr;
  logic [2:0]            samp_cnt;
  logic                  sampled_bit_q;
  logic                  bit_valid_q;
  logic                  noise_q;

  logic [PRESCALE_W-1:0] ps_clamped;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] win_lo;
  logic [PRESCALE_W-1:0] win_hi;
  logic [2:0]            n_samp;
  logic                  en_rise;
  logic                  in_window;
  logic                  last_sample;
  logic                  wrap;
  logic [4:0]            samp_next;
  vote_t                 vote;

  bit_synchronizer #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(RX_IDLE)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx_in),
    .q  (rx_s)
  );

  // On the rising-edge cycle ps_q/mode_q are still stale, but edge_cnt is 0
  // there and the window never starts below 2, so nothing depends on them.
  always_comb begin
    ps_clamped  = (smp.prescale < PS_MIN) ? PS_MIN : smp.prescale;
    en_rise     = smp.samp_en & ~samp_en_q;
    mid         = ps_q >> 1;
    half        = (mode_q == SAMP_MODE_5) ? PRESCALE_W'(2) : PRESCALE_W'(1);
    n_samp      = (mode_q == SAMP_MODE_5) ? 3'd5 : 3'd3;
    win_lo      = mid - half;
    win_hi      = mid + half;
    in_window   = (edge_cnt_q >= win_lo) && (edge_cnt_q <= win_hi);
    last_sample = (edge_cnt_q == win_hi);
    wrap        = (edge_cnt_q == ps_q - PRESCALE_W'(1));
    // Vote on the register contents including the sample being taken now,
    // so the result is registered in the same edge as the last sample.
    samp_next   = {samp_sr[3:0], rx_s};
    vote        = majority_vote(samp_next, mode_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_en_q     <= 1'b0;
      ps_q          <= PS_MIN;
      mode_q        <= SAMP_MODE_3;
      edge_cnt_q    <= '0;
      samp_sr       <= '0;
      samp_cnt      <= '0;
      sampled_bit_q <= RX_IDLE;
      bit_valid_q   <= 1'b0;
      noise_q       <= 1'b0;
    end else begin
      samp_en_q   <= smp.samp_en;
      bit_valid_q <= 1'b0;

      if (en_rise || (smp.samp_en && wrap)) begin
        ps_q   <= ps_clamped;
        mode_q <= smp.samp_mode;
      end

      if (!smp.samp_en) begin
        edge_cnt_q <= '0;
        samp_sr    <= '0;
        samp_cnt   <= '0;
      end else if (wrap) begin
        edge_cnt_q <= '0;
        samp_sr    <= '0;
        samp_cnt   <= '0;
      end else begin
        edge_cnt_q <= edge_cnt_q + PRESCALE_W'(1);
        if (in_window) begin
          samp_sr  <= samp_next;
          samp_cnt <= samp_cnt + 3'd1;
          if (last_sample && (samp_cnt == n_samp - 3'd1)) begin
            bit_valid_q   <= 1'b1;
            sampled_bit_q <= vote.value;
            noise_q       <= vote.noise;
          end
        end
      end
    end
  end

  assign smp.sampled_bit = sampled_bit_q;
  assign smp.bit_valid   = bit_valid_q;
  assign smp.noise_err   = noise_q;
  assign smp.edge_cnt    = edge_cnt_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler. Inputs change 1 time unit after the
// rising edge; outputs are checked at that same point, i.e. away from the edge.
// The strobe is expected in the cycle where edge_cnt = (ps/2)+h+1.
module tb_uart_rx_sampler;
  import uart_pkg::*;

  logic clk;
  logic rst;
  logic rx_in;
  int   vectors;
  int   miscompares;

  uart_rx_sampler_if #(.PRESCALE_W(6)) smp_if ();

  uart_rx_sampler #(
    .PRESCALE_W (6),
    .SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .rx_in(rx_in),
    .smp  (smp_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic lvl);
    smp_if.samp_en = 1'b0;
    rx_in = lvl;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx_in = 1'b1;
    smp_if.samp_en = 1'b0;
    smp_if.prescale = 6'd8;
    smp_if.samp_mode = SAMP_MODE_3;
    #12;
    vectors++; if (smp_if.sampled_bit !== 1'b1) begin miscompares++; $display("FAIL reset_bit got %b exp 1", smp_if.sampled_bit); end
    vectors++; if (smp_if.bit_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", smp_if.bit_valid); end
    vectors++; if (smp_if.noise_err !== 1'b0) begin miscompares++; $display("FAIL reset_noise got %b exp 0", smp_if.noise_err); end
    vectors++; if (smp_if.edge_cnt !== 6'd0) begin miscompares++; $display("FAIL reset_cnt got %0d exp 0", smp_if.edge_cnt); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  // prescale 8, 3-sample, line 0: window 3..5, strobe at 6, back-to-back bits.
  task automatic test_back_to_back();
    idle(3, 1'b0);
    smp_if.prescale = 6'd8;
    smp_if.samp_mode = SAMP_MODE_3;
    for (int k = 0; k < 24; k++) begin
      smp_if.samp_en = 1'b1;
      vectors++; if (smp_if.edge_cnt !== 6'(k % 8)) begin miscompares++; $display("FAIL b2b_cnt k=%0d got %0d exp %0d", k, smp_if.edge_cnt, k % 8); end
      vectors++; if (smp_if.bit_valid !== ((k % 8) == 6)) begin miscompares++; $display("FAIL b2b_valid k=%0d got %b", k, smp_if.bit_valid); end
      if ((k % 8) == 6) begin
        vectors++; if (smp_if.sampled_bit !== 1'b0) begin miscompares++; $display("FAIL b2b_bit k=%0d got %b exp 0", k, smp_if.sampled_bit); end
        vectors++; if (smp_if.noise_err !== 1'b0) begin miscompares++; $display("FAIL b2b_noise k=%0d got %b exp 0", k, smp_if.noise_err); end
      end
      tick();
    end
  endtask

  // prescale 4 is clamped to 8: same strobe position and 8-cycle wrap.
  task automatic test_prescale_clamp();
    idle(3, 1'b1);
    smp_if.prescale = 6'd4;
    smp_if.samp_mode = SAMP_MODE_3;
    for (int k = 0; k < 18; k++) begin
      smp_if.samp_en = 1'b1;
      vectors++; if (smp_if.edge_cnt !== 6'(k % 8)) begin miscompares++; $display("FAIL clamp_cnt k=%0d got %0d exp %0d", k, smp_if.edge_cnt, k % 8); end
      vectors++; if (smp_if.bit_valid !== ((k % 8) == 6)) begin miscompares++; $display("FAIL clamp_valid k=%0d got %b", k, smp_if.bit_valid); end
      if ((k % 8) == 6) begin
        vectors++; if (smp_if.sampled_bit !== 1'b1) begin miscompares++; $display("FAIL clamp_bit k=%0d got %b exp 1", k, smp_if.sampled_bit); end
        vectors++; if (smp_if.noise_err !== 1'b0) begin miscompares++; $display("FAIL clamp_noise k=%0d got %b exp 0", k, smp_if.noise_err); end
      end
      tick();
    end
  endtask

  // prescale 16, 5-sample: window 6..10, strobe at 11. rx_in driven in cycle
  // k reaches rx_s in cycle k+2, so a 0 at k=6 lands on sample 8.
  task automatic test_glitch();
    idle(3, 1'b1);
    smp_if.prescale = 6'd16;
    smp_if.samp_mode = SAMP_MODE_5;
    for (int k = 0; k < 17; k++) begin
      smp_if.samp_en = 1'b1;
      rx_in = (k == 6) ? 1'b0 : 1'b1;
      vectors++; if (smp_if.edge_cnt !== 6'(k % 16)) begin miscompares++; $display("FAIL glitch_cnt k=%0d got %0d exp %0d", k, smp_if.edge_cnt, k % 16); end
      vectors++; if (smp_if.bit_valid !== (k == 11)) begin miscompares++; $display("FAIL glitch_valid k=%0d got %b", k, smp_if.bit_valid); end
      if (k == 11) begin
        vectors++; if (smp_if.sampled_bit !== 1'b1) begin miscompares++; $display("FAIL glitch_bit got %b exp 1", smp_if.sampled_bit); end
        vectors++; if (smp_if.noise_err !== 1'b1) begin miscompares++; $display("FAIL glitch_noise got %b exp 1", smp_if.noise_err); end
      end
      tick();
    end
  endtask

  // rx_s is 0 at samples 6,7 and 1 at 8..10: majority 1, noisy.
  task automatic test_edge_in_window();
    idle(3, 1'b0);
    smp_if.prescale = 6'd16;
    smp_if.samp_mode = SAMP_MODE_5;
    for (int k = 0; k < 13; k++) begin
      smp_if.samp_en = 1'b1;
      rx_in = (k >= 6) ? 1'b1 : 1'b0;
      vectors++; if (smp_if.bit_valid !== (k == 11)) begin miscompares++; $display("FAIL slope_valid k=%0d got %b", k, smp_if.bit_valid); end
      if (k == 11) begin
        vectors++; if (smp_if.sampled_bit !== 1'b1) begin miscompares++; $display("FAIL slope_bit got %b exp 1", smp_if.sampled_bit); end
        vectors++; if (smp_if.noise_err !== 1'b1) begin miscompares++; $display("FAIL slope_noise got %b exp 1", smp_if.noise_err); end
      end
      tick();
    end
  endtask

  // Drop samp_en at edge_cnt 6 for 3 cycles; the restarted bit strobes at 10.
  task automatic test_abort();
    idle(3, 1'b0);
    smp_if.prescale = 6'd16;
    smp_if.samp_mode = SAMP_MODE_3;
    for (int k = 0; k < 9; k++) begin
      smp_if.samp_en = (k < 6);
      if (k <= 6) begin
        vectors++; if (smp_if.edge_cnt !== 6'(k)) begin miscompares++; $display("FAIL abort_cnt k=%0d got %0d exp %0d", k, smp_if.edge_cnt, k); end
      end else begin
        vectors++; if (smp_if.edge_cnt !== 6'd0) begin miscompares++; $display("FAIL abort_gap_cnt k=%0d got %0d exp 0", k, smp_if.edge_cnt); end
        vectors++; if (smp_if.sampled_bit !== 1'b1) begin miscompares++; $display("FAIL abort_gap_bit k=%0d got %b exp 1", k, smp_if.sampled_bit); end
      end
      vectors++; if (smp_if.bit_valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid k=%0d got %b exp 0", k, smp_if.bit_valid); end
      tick();
    end
    for (int k = 0; k < 12; k++) begin
      smp_if.samp_en = 1'b1;
      vectors++; if (smp_if.edge_cnt !== 6'(k)) begin miscompares++; $display("FAIL restart_cnt k=%0d got %0d exp %0d", k, smp_if.edge_cnt, k); end
      vectors++; if (smp_if.bit_valid !== (k == 10)) begin miscompares++; $display("FAIL restart_valid k=%0d got %b", k, smp_if.bit_valid); end
      if (k == 10) begin
        vectors++; if (smp_if.sampled_bit !== 1'b0) begin miscompares++; $display("FAIL restart_bit got %b exp 0", smp_if.sampled_bit); end
      end
      tick();
    end
  endtask

  // Reset at edge_cnt 7 of a 5-sample bit, samp_en kept high through it.
  task automatic test_reset_midbit();
    idle(3, 1'b0);
    smp_if.prescale = 6'd16;
    smp_if.samp_mode = SAMP_MODE_5;
    for (int k = 0; k < 7; k++) begin
      smp_if.samp_en = 1'b1;
      vectors++; if (smp_if.edge_cnt !== 6'(k)) begin miscompares++; $display("FAIL rstmid_cnt k=%0d got %0d exp %0d", k, smp_if.edge_cnt, k); end
      tick();
    end
    rst = 1'b0;
    #1;
    vectors++; if (smp_if.edge_cnt !== 6'd0) begin miscompares++; $display("FAIL rstmid_async_cnt got %0d exp 0", smp_if.edge_cnt); end
    vectors++; if (smp_if.sampled_bit !== 1'b1) begin miscompares++; $display("FAIL rstmid_async_bit got %b exp 1", smp_if.sampled_bit); end
    vectors++; if (smp_if.bit_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_async_valid got %b exp 0", smp_if.bit_valid); end
    vectors++; if (smp_if.noise_err !== 1'b0) begin miscompares++; $display("FAIL rstmid_async_noise got %b exp 0", smp_if.noise_err); end
    repeat (2) begin
      tick();
      vectors++; if (smp_if.bit_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_hold_valid got %b exp 0", smp_if.bit_valid); end
    end
    rst = 1'b1;
    for (int k = 0; k < 13; k++) begin
      vectors++; if (smp_if.edge_cnt !== 6'(k)) begin miscompares++; $display("FAIL rstrel_cnt k=%0d got %0d exp %0d", k, smp_if.edge_cnt, k); end
      vectors++; if (smp_if.bit_valid !== (k == 11)) begin miscompares++; $display("FAIL rstrel_valid k=%0d got %b", k, smp_if.bit_valid); end
      if (k == 11) begin
        vectors++; if (smp_if.sampled_bit !== 1'b0) begin miscompares++; $display("FAIL rstrel_bit got %b exp 0", smp_if.sampled_bit); end
        vectors++; if (smp_if.noise_err !== 1'b0) begin miscompares++; $display("FAIL rstrel_noise got %b exp 0", smp_if.noise_err); end
      end
      tick();
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_back_to_back();
    test_prescale_clamp();
    test_glitch();
    test_edge_in_window();
    test_abort();
    test_reset_midbit();
    idle(2, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
